// File: rtl/sr_port_arbiter.sv
// Round-robin owner arbitration for the chip's single config shift-register port
// (ClkSR/Si/Ld + En_Cnfg_Pix) shared by the DAC SR engine (0) and pixel SR engine (1).
module sr_port_arbiter #(
    parameter logic [7:0]  SETUP_CYC = 8'd4,
    parameter logic [7:0]  LD_WAIT   = 8'd8,
    parameter logic [7:0]  GUARD_CYC = 8'd4,
    parameter logic [15:0] TIMEOUT   = 16'd0
) (
    input  logic       SPI_CLK,
    input  logic       nRST,
    input  logic [1:0] REQ,
    input  logic [1:0] SCLK_IN,
    input  logic [1:0] SDI_IN,
    input  logic [1:0] SLD_IN,
    input  logic       CLR_ERR,
    output logic [1:0] GNT,
    output logic       ClkSR,
    output logic       Si,
    output logic       Ld,
    output logic       En_Cnfg_Pix,
    output logic       BUSY,
    output logic       TIMEOUT_ERR
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        GRANT,
        HOLD,
        GUARD
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] gcnt_q, gcnt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        sr_en_q, sr_en_d;
    logic        ld_en_q, ld_en_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        owner_req;
    logic        err_set;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q + 8'd1;
        gcnt_d    = gcnt_q;
        err_set   = 1'b0;
        owner_req = REQ[owner_q];

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (REQ != 2'b00) begin
                    owner_d = (REQ == 2'b11) ? ~last_q : REQ[1];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!owner_req) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                end else if (cnt_q == SETUP_CYC - 8'd1) begin
                    state_d = GRANT;
                    cnt_d   = '0;
                    gcnt_d  = '0;
                end
            end
            GRANT: begin
                cnt_d = '0;
                // a normal release wins over a watchdog expiry in the same cycle
                if (!owner_req) begin
                    state_d = HOLD;
                end else if ((TIMEOUT != '0) && (gcnt_q == TIMEOUT)) begin
                    state_d = GUARD;
                    err_set = 1'b1;
                end else if (gcnt_q != '1) begin
                    gcnt_d = gcnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (cnt_q == LD_WAIT - 8'd1) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                end
            end
            GUARD: begin
                if (cnt_q == GUARD_CYC - 8'd1) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        gnt_d = '0;
        if (state_d == GRANT) begin
            gnt_d[owner_d] = 1'b1;
        end
        sr_en_d = (state_d == GRANT);
        ld_en_d = (state_d == GRANT) || (state_d == HOLD);
        busy_d  = (state_d != IDLE);
        err_d   = err_set ? 1'b1 : (CLR_ERR ? 1'b0 : err_q);
    end

    always_ff @(posedge SPI_CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            gnt_q   <= '0;
            sr_en_q <= 1'b0;
            ld_en_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            gnt_q   <= gnt_d;
            sr_en_q <= sr_en_d;
            ld_en_q <= ld_en_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Port signals are clock-derived, so they are gated rather than re-registered.
    assign ClkSR       = sr_en_q & SCLK_IN[owner_q];
    assign Si          = sr_en_q & SDI_IN[owner_q];
    assign Ld          = ld_en_q & SLD_IN[owner_q];
    assign GNT         = gnt_q;
    assign En_Cnfg_Pix = owner_q;
    assign BUSY        = busy_q;
    assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_sr_port_arbiter.sv
// Self-checking bench for sr_port_arbiter: timestamp-based ownership model,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_sr_port_arbiter;

    localparam int SETUP = 4;
    localparam int LDW   = 8;
    localparam int GRD   = 4;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req, sclk, sdi, sld;
    logic       clr;
    logic [1:0] GNT;
    logic       ClkSR, Si, Ld, En_Cnfg_Pix, BUSY, TIMEOUT_ERR;

    sr_port_arbiter #(
        .SETUP_CYC(8'd4),
        .LD_WAIT  (8'd8),
        .GUARD_CYC(8'd4),
        .TIMEOUT  (16'd100)
    ) dut (
        .SPI_CLK    (clk),
        .nRST       (rst_n),
        .REQ        (req),
        .SCLK_IN    (sclk),
        .SDI_IN     (sdi),
        .SLD_IN     (sld),
        .CLR_ERR    (clr),
        .GNT        (GNT),
        .ClkSR      (ClkSR),
        .Si         (Si),
        .Ld         (Ld),
        .En_Cnfg_Pix(En_Cnfg_Pix),
        .BUSY       (BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: an ownership is described by its selection edge, grant edge,
    // release edge and end edge; outputs follow from comparing edge numbers.
    int k = 0;
    bit m_act, m_granted, m_done, m_own, m_last, m_err;
    int t_sel, t_g, t_end, ld_until;
    bit rand_sld = 1'b1;

    function automatic void model_reset();
        m_act     = 1'b0;
        m_granted = 1'b0;
        m_done    = 1'b0;
        m_own     = 1'b0;
        m_last    = 1'b1;
        m_err     = 1'b0;
        ld_until  = 0;
        t_sel     = 0;
        t_g       = 0;
        t_end     = 0;
    endfunction

    function automatic logic [1:0] m_gnt();
        if (m_act && m_granted && !m_done) return m_own ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_ld_en();
        return m_act && m_granted && (!m_done || (k < ld_until));
    endfunction

    task automatic model_edge();
        bit set_err;
        set_err = 1'b0;
        k++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_act) begin
            if (req != 2'b00) begin
                m_own     = (req == 2'b11) ? !m_last : req[1];
                m_act     = 1'b1;
                m_granted = 1'b0;
                m_done    = 1'b0;
                t_sel     = k;
            end
        end else if (!m_done) begin
            if (!m_granted) begin
                if (!req[m_own]) begin
                    m_done   = 1'b1;
                    ld_until = 0;
                    t_end    = k + GRD;
                end else if (k == t_sel + SETUP) begin
                    m_granted = 1'b1;
                    t_g       = k;
                end
            end else begin
                if (!req[m_own]) begin
                    m_done   = 1'b1;
                    ld_until = k + LDW;
                    t_end    = k + LDW + GRD;
                end else if ((k - 1 - t_g) == TMO) begin
                    m_done   = 1'b1;
                    set_err  = 1'b1;
                    ld_until = k;
                    t_end    = k + GRD;
                end
            end
        end else if (k == t_end) begin
            m_act  = 1'b0;
            m_last = m_own;
        end
        m_err = set_err ? 1'b1 : (clr ? 1'b0 : m_err);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, k, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [1:0] g;
        g = m_gnt();
        chk("gnt",   GNT, g);
        chk("en",    En_Cnfg_Pix, m_own);
        chk("busy",  BUSY, m_act);
        chk("err",   TIMEOUT_ERR, m_err);
        chk("clksr", ClkSR, (g != 2'b00) & sclk[m_own]);
        chk("si",    Si,    (g != 2'b00) & sdi[m_own]);
        chk("ld",    Ld,    m_ld_en() & sld[m_own]);
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
        sclk = 2'($urandom_range(3));
        sdi  = 2'($urandom_range(3));
        if (rand_sld) sld = 2'($urandom_range(3));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!BUSY && !m_act) return;
            step();
        end
        n_checks++;
        n_fail++;
        $display("FAIL idle_wait at edge %0d: busy=%0b, required 0 within 400 cycles", k, BUSY);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: simulation did not complete");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        sclk  = 2'b00;
        sdi   = 2'b00;
        sld   = 2'b00;
        clr   = 1'b0;
        model_reset();
        repeat (3) step();
        chk("rst_gnt",  GNT, 2'b00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_en",   En_Cnfg_Pix, 1'b0);
        chk("rst_err",  TIMEOUT_ERR, 1'b0);
        rst_n = 1'b1;
        repeat (2) step();

        // T1 + T3: sole requester 0, setup latency, pass-through, Ld window
        rand_sld = 1'b0;
        sld = 2'b00;
        req = 2'b01;
        repeat (4) step();
        chk("t1_gnt_setup", GNT, 2'b00);
        step();
        chk("t1_gnt", GNT, 2'b01);
        chk("t1_en",  En_Cnfg_Pix, 1'b0);
        sclk = 2'b01;
        #1 chk("t1_clksr_hi", ClkSR, 1'b1);
        sclk = 2'b10;
        #1 chk("t1_clksr_lo", ClkSR, 1'b0);
        repeat (15) step();
        req = 2'b00;
        repeat (3) step();
        sld = 2'b01;
        #1 chk("t3_ld_in_window", Ld, 1'b1);
        step();
        sld = 2'b00;
        repeat (6) step();
        sld = 2'b01;
        #1 chk("t3_ld_late", Ld, 1'b0);
        sld = 2'b00;
        repeat (2) step();
        chk("t3_busy_guard", BUSY, 1'b1);
        step();
        chk("t3_busy_done", BUSY, 1'b0);
        rand_sld = 1'b1;

        // T2: both requesting from reset, owner 0 first then owner 1
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
        req = 2'b11;
        repeat (4) step();
        chk("t2_gnt_setup", GNT, 2'b00);
        step();
        chk("t2_gnt0", GNT, 2'b01);
        chk("t2_en0",  En_Cnfg_Pix, 1'b0);
        repeat (10) step();
        req = 2'b10;
        repeat (13) step();
        chk("t2_en_hold", En_Cnfg_Pix, 1'b0);
        step();
        chk("t2_en_switch", En_Cnfg_Pix, 1'b1);
        chk("t2_gnt_sel",   GNT, 2'b00);
        sclk = 2'b11;
        sdi  = 2'b11;
        #1;
        chk("t2_clksr_low", ClkSR, 1'b0);
        chk("t2_si_low",    Si, 1'b0);
        repeat (3) step();
        chk("t2_gnt1_pre", GNT, 2'b00);
        step();
        chk("t2_gnt1", GNT, 2'b10);
        req = 2'b00;
        wait_idle();

        // T4: watchdog on requester 1
        req = 2'b10;
        repeat (5) step();
        chk("t4_gnt", GNT, 2'b10);
        repeat (100) step();
        chk("t4_gnt_last", GNT, 2'b10);
        chk("t4_err_pre",  TIMEOUT_ERR, 1'b0);
        step();
        chk("t4_gnt_drop", GNT, 2'b00);
        chk("t4_err_set",  TIMEOUT_ERR, 1'b1);
        repeat (300) step();
        req = 2'b00;
        wait_idle();
        chk("t4_err_sticky", TIMEOUT_ERR, 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t4_err_clr", TIMEOUT_ERR, 1'b0);

        // T5: async reset during a grant to requester 1
        req = 2'b10;
        repeat (8) step();
        chk("t5_gnt", GNT, 2'b10);
        rand_sld = 1'b0;
        sclk = 2'b11;
        sdi  = 2'b11;
        sld  = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("t5_gnt",   GNT, 2'b00);
        chk("t5_clksr", ClkSR, 1'b0);
        chk("t5_si",    Si, 1'b0);
        chk("t5_ld",    Ld, 1'b0);
        chk("t5_busy",  BUSY, 1'b0);
        chk("t5_en",    En_Cnfg_Pix, 1'b0);
        model_reset();
        rand_sld = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        req = 2'b00;
        repeat (2) step();

        // T6: owner request dropped during setup
        req = 2'b01;
        repeat (2) step();
        req = 2'b00;
        repeat (4) step();
        chk("t6_busy_guard", BUSY, 1'b1);
        chk("t6_no_gnt",     GNT, 2'b00);
        step();
        chk("t6_busy_done",  BUSY, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (req[r]) begin
                    if ($urandom_range((i < 1500) ? 23 : 150) == 0) req[r] = 1'b0;
                end else begin
                    if ($urandom_range(9) == 0) req[r] = 1'b1;
                end
            end
            clr = ($urandom_range(63) == 0);
            step();
        end
        clr = 1'b0;
        req = 2'b00;
        wait_idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
